// File: rtl/shared_op_pipe_node.sv
// Shared arithmetic unit: joins {left, right, condition}, computes OP through a
// fixed-latency stallable pipeline and emits {condition, result} channel pairs.
module shared_op_pipe_node #(
  parameter int INPUTS        = 3,
  parameter int OUTPUTS       = 2,
  parameter int DATA_IN_SIZE  = 32,
  parameter int DATA_OUT_SIZE = 32,
  parameter int COND_SIZE     = 3,
  parameter int LATENCY       = 4,
  parameter int OP            = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INPUTS*DATA_IN_SIZE-1:0]     data_in_bus,
  input  logic [INPUTS-1:0]                  valid_in_bus,
  output logic [INPUTS-1:0]                  ready_in_bus,
  output logic [OUTPUTS*DATA_OUT_SIZE-1:0]   data_out_bus,
  output logic [OUTPUTS-1:0]                 valid_out_bus,
  input  logic [OUTPUTS-1:0]                 ready_out_bus
);

  logic [DATA_OUT_SIZE-1:0] lhs, rhs, result_d, cond_ext;
  logic [COND_SIZE-1:0]     cond_d;
  logic [LATENCY-1:0]       v_q, v_d;
  logic [COND_SIZE-1:0]     cond_q [LATENCY];
  logic [DATA_OUT_SIZE-1:0] data_q [LATENCY];
  logic                     all_valid, pop, en, fire;
  logic                     unused_cond_bits;

  assign lhs    = data_in_bus[0*DATA_IN_SIZE +: DATA_OUT_SIZE];
  assign rhs    = data_in_bus[1*DATA_IN_SIZE +: DATA_OUT_SIZE];
  assign cond_d = data_in_bus[2*DATA_IN_SIZE +: COND_SIZE];
  assign unused_cond_bits = ^data_in_bus[2*DATA_IN_SIZE+COND_SIZE +: DATA_IN_SIZE-COND_SIZE];

  // A token leaves only when both output channels accept in the same cycle.
  assign all_valid = &valid_in_bus;
  assign pop       = v_q[LATENCY-1] & ready_out_bus[0] & ready_out_bus[1];
  assign en        = ~v_q[LATENCY-1] | pop;
  assign fire      = all_valid & en;

  always_comb begin
    ready_in_bus = '0;
    for (int i = 0; i < INPUTS; i++) begin
      ready_in_bus[i] = en;
      for (int j = 0; j < INPUTS; j++) begin
        if (j != i) ready_in_bus[i] = ready_in_bus[i] & valid_in_bus[j];
      end
    end
  end

  always_comb begin
    result_d = '0;
    case (OP)
      0:       result_d = lhs + rhs;
      1:       result_d = lhs - rhs;
      default: result_d = lhs * rhs;
    endcase
  end

  always_comb begin
    v_d = v_q;
    if (en) begin
      v_d[0] = fire;
      for (int s = 1; s < LATENCY; s++) v_d[s] = v_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  // Payload needs no reset; only the valid bits define what is in flight.
  always_ff @(posedge clk) begin
    if (en) begin
      cond_q[0] <= cond_d;
      data_q[0] <= result_d;
      for (int s = 1; s < LATENCY; s++) begin
        cond_q[s] <= cond_q[s-1];
        data_q[s] <= data_q[s-1];
      end
    end
  end

  always_comb begin
    cond_ext = '0;
    cond_ext[COND_SIZE-1:0] = cond_q[LATENCY-1];
  end

  assign valid_out_bus = {OUTPUTS{v_q[LATENCY-1]}};
  assign data_out_bus  = {cond_ext, data_q[LATENCY-1]};

endmodule

// File: tb/tb_shared_op_pipe_node.sv
// Bench for shared_op_pipe_node: three instances (add, sub, mul) share stimulus
// and are checked against a token-position queue model of the pipeline.
module tb_shared_op_pipe_node;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_a, op_b, op_c;
  logic [2:0]  vin;
  logic [1:0]  rout;
  wire  [95:0] din = {op_c, op_b, op_a};
  wire  [2:0]  rin0, rin1, rin2;
  wire  [63:0] dout0, dout1, dout2;
  wire  [1:0]  vout0, vout1, vout2;

  always #5 clk = ~clk;

  shared_op_pipe_node #(.LATENCY(LAT), .OP(0)) u_add (
    .clk(clk), .rst(rst), .data_in_bus(din), .valid_in_bus(vin), .ready_in_bus(rin0),
    .data_out_bus(dout0), .valid_out_bus(vout0), .ready_out_bus(rout));
  shared_op_pipe_node #(.LATENCY(LAT), .OP(1)) u_sub (
    .clk(clk), .rst(rst), .data_in_bus(din), .valid_in_bus(vin), .ready_in_bus(rin1),
    .data_out_bus(dout1), .valid_out_bus(vout1), .ready_out_bus(rout));
  shared_op_pipe_node #(.LATENCY(LAT), .OP(2)) u_mul (
    .clk(clk), .rst(rst), .data_in_bus(din), .valid_in_bus(vin), .ready_in_bus(rin2),
    .data_out_bus(dout2), .valid_out_bus(vout2), .ready_out_bus(rout));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    int          pos;
  } tok_t;

  tok_t         q[$];
  int           n_cmp = 0, n_bad = 0;
  logic         head_v, en_e, fire_e;
  logic [2:0]   rin_e;
  logic [206:0] exp_all;
  wire  [206:0] obs_all = {rin0, rin1, rin2, vout0, vout1, vout2,
                           head_v ? {dout0, dout1, dout2} : 192'b0};

  // Tokens sit at a position 0..LAT-1; the oldest one is visible once it reaches LAT-1.
  task automatic model_eval();
    logic [2:0]   m;
    logic [31:0]  ha, hb, ce;
    logic [191:0] d;
    head_v = (q.size() > 0) && (q[0].pos == LAT-1);
    en_e   = !head_v || (rout == 2'b11);
    for (int i = 0; i < 3; i++) begin
      m = vin;
      m[i] = 1'b1;
      rin_e[i] = en_e && (&m);
    end
    fire_e = (&vin) && en_e;
    d = '0;
    if (head_v) begin
      ha = q[0].a;
      hb = q[0].b;
      ce = {29'b0, q[0].c};
      d  = {ce, ha + hb, ce, ha - hb, ce, ha * hb};
    end
    exp_all = {rin_e, rin_e, rin_e, {6{head_v}}, d};
  endtask

  task automatic model_clock();
    tok_t t;
    model_eval();
    @(posedge clk);
    if (rst) q.delete();
    else if (en_e) begin
      if (head_v) t = q.pop_front();
      foreach (q[k]) q[k].pos = q[k].pos + 1;
      if (fire_e) begin
        t.a = op_a; t.b = op_b; t.c = op_c[2:0]; t.pos = 0;
        q.push_back(t);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vin = 3'b000; rout = 2'b11;
    op_a = '0; op_b = '0; op_c = '0;
    repeat (2) model_clock();
    rst = 1'b0;
    model_eval(); @(negedge clk);
    n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL reset_state got=%h exp=%h", obs_all, exp_all); end
    n_cmp++; if ({vout0, vout1, vout2} !== 6'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", {vout0, vout1, vout2}); end
    vin = 3'b011; #1;
    model_eval();
    n_cmp++; if (rin0 !== 3'b100) begin n_bad++; $display("FAIL reset_join got=%b exp=100", rin0); end
    n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL reset_join_all got=%h exp=%h", obs_all, exp_all); end
    vin = 3'b000;
    model_clock();
  endtask

  task automatic test_single();
    op_a = 32'd7; op_b = 32'd6; op_c = ($urandom() & 32'hFFFF_FFF8) | 32'd5;
    vin = 3'b111; rout = 2'b11;
    model_eval(); @(negedge clk);
    n_cmp++; if (rin2 !== 3'b111) begin n_bad++; $display("FAIL single_accept got=%b exp=111", rin2); end
    model_clock();
    vin = 3'b000;
    for (int k = 1; k <= 6; k++) begin
      model_eval(); @(negedge clk);
      n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL single k=%0d got=%h exp=%h", k, obs_all, exp_all); end
      n_cmp++; if ((vout2 === 2'b11) != (k == LAT)) begin n_bad++; $display("FAIL single_latency k=%0d valid=%b", k, vout2); end
      if (k == LAT) begin
        n_cmp++; if (dout2 !== {32'd5, 32'd42}) begin n_bad++; $display("FAIL single_mul got=%h exp=%h", dout2, {32'd5, 32'd42}); end
      end
      model_clock();
    end
  endtask

  task automatic test_streaming();
    int cnt = 0, first = -1, last = -1;
    rout = 2'b11;
    for (int cyc = 0; cyc < 16 + LAT + 3; cyc++) begin
      if (cyc < 16) begin
        op_a = 32'(cyc); op_b = 32'd100;
        op_c = ($urandom() & 32'hFFFF_FFF8) | 32'(cyc % 8);
        vin = 3'b111;
      end else vin = 3'b000;
      model_eval(); @(negedge clk);
      n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all); end
      if (vout0 === 2'b11) begin
        n_cmp++;
        if (dout0 !== {32'(cnt % 8), 32'(100 + cnt)}) begin
          n_bad++; $display("FAIL stream_add idx=%0d got=%h exp=%h", cnt, dout0, {32'(cnt % 8), 32'(100 + cnt)});
        end
        if (first < 0) first = cyc;
        last = cyc;
        cnt++;
      end
      model_clock();
    end
    n_cmp++;
    if (cnt != 16 || last - first != 15 || first != LAT) begin
      n_bad++; $display("FAIL stream_gapless count=%0d span=%0d first=%0d exp 16/15/%0d", cnt, last - first, first, LAT);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0;
    op_a = $urandom(); op_b = $urandom(); op_c = $urandom();
    for (int cyc = 0; cyc < 40; cyc++) begin
      rout = (cyc < 8) ? 2'b00 : 2'b11;
      vin  = (sent < 10) ? 3'b111 : 3'b000;
      model_eval(); @(negedge clk);
      n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL bp cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all); end
      if (cyc >= LAT && cyc < 8) begin
        n_cmp++; if (rin1 !== 3'b000) begin n_bad++; $display("FAIL bp_full cyc=%0d got=%b exp=000", cyc, rin1); end
      end
      if (vout1 === 2'b11 && rout == 2'b11) got++;
      model_clock();
      if (fire_e) begin
        sent++;
        op_a = $urandom(); op_b = $urandom(); op_c = $urandom();
      end
    end
    n_cmp++; if (got != 10 || sent != 10) begin n_bad++; $display("FAIL bp_count got=%0d sent=%0d exp 10", got, sent); end
  endtask

  task automatic test_partial_wrap();
    bit seen = 1'b0;
    op_a = 32'd0; op_b = 32'd1; op_c = $urandom();
    vin = 3'b111; rout = 2'b01;
    model_clock();
    vin = 3'b000;
    for (int w = 0; w < 10 && !seen; w++) begin
      model_eval(); @(negedge clk);
      n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL wrap_wait w=%0d got=%h exp=%h", w, obs_all, exp_all); end
      if (vout1 === 2'b11) seen = 1'b1;
      else model_clock();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL wrap_timeout valid=%b exp=11", vout1); end
    for (int h = 0; h < 3; h++) begin
      rout = (h == 1) ? 2'b10 : 2'b01;
      model_clock();
      model_eval(); @(negedge clk);
      n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL wrap_hold h=%0d got=%h exp=%h", h, obs_all, exp_all); end
      n_cmp++;
      if (vout1 !== 2'b11 || dout1 !== {29'b0, op_c[2:0], 32'hFFFF_FFFF}) begin
        n_bad++; $display("FAIL wrap_value h=%0d valid=%b got=%h", h, vout1, dout1);
      end
    end
    rout = 2'b11;
    model_clock();
    model_eval(); @(negedge clk);
    n_cmp++; if (vout1 !== 2'b00) begin n_bad++; $display("FAIL wrap_pop got=%b exp=00", vout1); end
    model_clock();
  endtask

  task automatic test_join_skew();
    int outs = 0;
    rout = 2'b11;
    op_a = $urandom(); op_b = $urandom(); op_c = $urandom();
    vin = 3'b011;
    for (int s = 0; s < 2; s++) begin
      model_eval(); @(negedge clk);
      n_cmp++; if (rin2 !== 3'b100) begin n_bad++; $display("FAIL skew_wait s=%0d got=%b exp=100", s, rin2); end
      model_clock();
    end
    vin = 3'b111;
    model_eval(); @(negedge clk);
    n_cmp++; if (rin2 !== 3'b111) begin n_bad++; $display("FAIL skew_join got=%b exp=111", rin2); end
    model_clock();
    vin = 3'b000;
    for (int k = 0; k < LAT + 2; k++) begin
      model_eval(); @(negedge clk);
      n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL skew_drain k=%0d got=%h exp=%h", k, obs_all, exp_all); end
      if (vout2 === 2'b11) outs++;
      model_clock();
    end
    n_cmp++; if (outs != 1) begin n_bad++; $display("FAIL skew_count got=%0d exp=1", outs); end
  endtask

  task automatic test_midflight_reset();
    int outs = 0;
    logic [31:0] sa, sb, sc;
    rout = 2'b00;
    for (int k = 0; k < 5; k++) begin
      vin = (k < 3) ? 3'b111 : 3'b000;
      op_a = $urandom(); op_b = $urandom(); op_c = $urandom();
      model_eval(); @(negedge clk);
      n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL mrst_fill k=%0d got=%h exp=%h", k, obs_all, exp_all); end
      model_clock();
    end
    rst = 1'b1;
    model_clock();
    rst = 1'b0; rout = 2'b11;
    for (int k = 0; k < LAT + 2; k++) begin
      model_eval(); @(negedge clk);
      n_cmp++; if (vout2 !== 2'b00) begin n_bad++; $display("FAIL mrst_drain k=%0d got=%b exp=00", k, vout2); end
      model_clock();
    end
    sa = $urandom(); sb = $urandom(); sc = $urandom();
    op_a = sa; op_b = sb; op_c = sc; vin = 3'b111;
    model_clock();
    vin = 3'b000;
    for (int k = 0; k < LAT + 2; k++) begin
      model_eval(); @(negedge clk);
      n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL mrst_after k=%0d got=%h exp=%h", k, obs_all, exp_all); end
      if (vout2 === 2'b11) begin
        outs++;
        n_cmp++;
        if (dout2 !== {29'b0, sc[2:0], sa * sb}) begin
          n_bad++; $display("FAIL mrst_value got=%h exp=%h", dout2, {29'b0, sc[2:0], sa * sb});
        end
      end
      model_clock();
    end
    n_cmp++; if (outs != 1) begin n_bad++; $display("FAIL mrst_count got=%0d exp=1", outs); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 3; i++) vin[i] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) rout[i] = ($urandom_range(0, 3) != 0);
      op_a = $urandom(); op_b = $urandom(); op_c = $urandom();
      rst = ($urandom_range(0, 59) == 0);
      model_eval(); @(negedge clk);
      n_cmp++; if (obs_all !== exp_all) begin n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all); end
      model_clock();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_partial_wrap();
    test_join_skew();
    test_midflight_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
